instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 120 ++++++++++++
 tb/tb_instr_fetch.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding imem read at a time, results buffered
// in a small in-order queue for the decoder; redirect flushes everything.
module instr_fetch #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 32,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PC_WIDTH-1:0]    pc,
    input  logic                   pc_valid,
    output logic                   pc_ready,
    input  logic                   redirect,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    instr_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready
);

    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [PC_WIDTH-1:0]    addr_q;
    logic [INSTR_WIDTH-1:0] data_mem [QUEUE_DEPTH];
    logic [PC_WIDTH-1:0]    pc_mem   [QUEUE_DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]       count;
    logic                   accept;
    logic                   push;
    logic                   pop;
    logic                   not_empty;

    // Fetches only start from IDLE, so the outstanding slot is implicit
    assign not_empty = (count != '0);
    assign pc_ready  = rst && (state_q == IDLE) && (count < DEPTH_C) && !redirect;
    assign accept    = pc_valid && pc_ready;
    assign push      = (state_q == WAIT) && imem_ack && !redirect;
    assign pop       = not_empty && instr_ready && !redirect;

    assign imem_req    = (state_q != IDLE);
    assign imem_addr   = addr_q;
    assign instr_valid = not_empty;
    assign instr       = not_empty ? data_mem[rd_ptr] : '0;
    assign instr_pc    = not_empty ? pc_mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = WAIT;
            WAIT: begin
                if (imem_ack) begin
                    state_d = IDLE;
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: if (imem_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
        end else if (accept) begin
            addr_q <= pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: validity is tracked by count alone
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= addr_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: vector table of single fetches, scoreboard on the
// decoder side, directed sequences for backpressure, redirect and reset.
module tb_instr_fetch;

    localparam int PW = 8;
    localparam int IW = 32;
    localparam int QD = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] pc;
    logic          pc_valid;
    logic          pc_ready;
    logic          redirect;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_rdata;
    logic [IW-1:0] instr;
    logic [PW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;

    always #5 clk = ~clk;

    instr_fetch #(
        .PC_WIDTH(PW),
        .INSTR_WIDTH(IW),
        .QUEUE_DEPTH(QD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pc(pc),
        .pc_valid(pc_valid),
        .pc_ready(pc_ready),
        .redirect(redirect),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready)
    );

    typedef struct {
        logic [PW-1:0] pc;
        logic [IW-1:0] data;
    } exp_t;

    typedef struct {
        logic [PW-1:0] pc;
        logic [IW-1:0] rdata;
        int            dly;
        logic [IW-1:0] exp_instr;
        logic [PW-1:0] exp_pc;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[5];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Decoder-side scoreboard: every pop must match the oldest expected entry
    always @(negedge clk) begin
        if (rst && !redirect && instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual_pc=0x%0h required=none",
                         instr_pc);
            end else begin
                mon_e = sb.pop_front();
                check("sb_pc", 64'(instr_pc), 64'(mon_e.pc));
                check("sb_instr", 64'(instr), 64'(mon_e.data));
            end
        end
    end

    task automatic fetch(input logic [PW-1:0] a, input logic [IW-1:0] d,
                         input int dly, input bit keep);
        pc       = a;
        pc_valid = 1'b1;
        #1;
        check("accept_ready", 64'(pc_ready), 64'h1);
        step;
        pc_valid = 1'b0;
        pc       = '0;
        #1;
        check("req_issued", 64'(imem_req), 64'h1);
        check("req_addr", 64'(imem_addr), 64'(a));
        for (int k = 0; k < dly; k++) begin
            step;
            check("req_hold", 64'(imem_req), 64'h1);
            check("addr_hold", 64'(imem_addr), 64'(a));
        end
        imem_ack   = 1'b1;
        imem_rdata = d;
        if (keep) sb.push_back(exp_t'{pc: a, data: d});
        step;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        #1;
        check("req_dropped", 64'(imem_req), 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        vecs[0] = '{8'h04, 32'h0050_0093, 0, 32'h0050_0093, 8'h04};
        vecs[1] = '{8'h08, 32'h1234_5678, 1, 32'h1234_5678, 8'h08};
        vecs[2] = '{8'hFC, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF, 8'hFC};
        vecs[3] = '{8'h00, 32'h0000_0000, 0, 32'h0000_0000, 8'h00};
        vecs[4] = '{8'h80, 32'hA5A5_A5A5, 3, 32'hA5A5_A5A5, 8'h80};

        rst         = 1'b0;
        pc          = 8'h55;
        pc_valid    = 1'b1;
        redirect    = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b1;
        #2;
        check("rst_pc_ready", 64'(pc_ready), 64'h0);
        check("rst_req", 64'(imem_req), 64'h0);
        check("rst_addr", 64'(imem_addr), 64'h0);
        check("rst_valid", 64'(instr_valid), 64'h0);
        check("rst_instr", 64'(instr), 64'h0);
        check("rst_instr_pc", 64'(instr_pc), 64'h0);
        step;
        step;
        check("rst_hold_req", 64'(imem_req), 64'h0);
        rst      = 1'b1;
        pc_valid = 1'b0;
        pc       = '0;
        step;
        check("empty_ready_noop", 64'(instr_valid), 64'h0);

        // Single fetches with varying ack latency; decoder always ready
        for (int i = 0; i < 5; i++) begin
            fetch(vecs[i].pc, vecs[i].rdata, vecs[i].dly, 1'b1);
            check("vec_valid", 64'(instr_valid), 64'h1);
            check("vec_instr", 64'(instr), 64'(vecs[i].exp_instr));
            check("vec_pc", 64'(instr_pc), 64'(vecs[i].exp_pc));
            step;
            check("vec_popped", 64'(instr_valid), 64'h0);
        end

        // Backpressure: two queued entries block the third fetch
        instr_ready = 1'b0;
        fetch(8'h00, 32'h0000_0013, 0, 1'b1);
        fetch(8'h04, 32'h0010_0093, 0, 1'b1);
        pc       = 8'h08;
        pc_valid = 1'b1;
        #1;
        check("bp_full_ready", 64'(pc_ready), 64'h0);
        step;
        check("bp_still_blocked", 64'(pc_ready), 64'h0);
        check("bp_no_req", 64'(imem_req), 64'h0);
        check("bp_head", 64'(instr_pc), 64'h00);
        instr_ready = 1'b1;
        #1;
        check("bp_ready_pop_cycle", 64'(pc_ready), 64'h0);
        step;
        instr_ready = 1'b0;
        #1;
        check("bp_ready_after_pop", 64'(pc_ready), 64'h1);
        check("bp_head_next", 64'(instr_pc), 64'h04);
        fetch(8'h08, 32'h0020_0113, 0, 1'b1);
        instr_ready = 1'b1;
        step;
        step;
        check("bp_drained", 64'(instr_valid), 64'h0);

        // Redirect while a request is outstanding; late ack is dropped
        pc       = 8'h10;
        pc_valid = 1'b1;
        #1;
        check("rd_accept", 64'(pc_ready), 64'h1);
        step;
        pc_valid = 1'b0;
        #1;
        check("rd_req", 64'(imem_req), 64'h1);
        redirect = 1'b1;
        #1;
        check("rd_ready_low", 64'(pc_ready), 64'h0);
        step;
        redirect = 1'b0;
        pc       = 8'h30;
        pc_valid = 1'b1;
        #1;
        check("drop_ready", 64'(pc_ready), 64'h0);
        check("drop_req", 64'(imem_req), 64'h1);
        check("drop_addr", 64'(imem_addr), 64'h10);
        step;
        check("drop_ready2", 64'(pc_ready), 64'h0);
        step;
        check("drop_ready3", 64'(pc_ready), 64'h0);
        step;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        check("drop_ack_ready", 64'(pc_ready), 64'h0);
        step;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        #1;
        check("drop_no_valid", 64'(instr_valid), 64'h0);
        check("drop_req_off", 64'(imem_req), 64'h0);
        check("drop_idle_ready", 64'(pc_ready), 64'h1);
        fetch(8'h30, 32'h00C0_0113, 0, 1'b1);
        check("after_drop_pc", 64'(instr_pc), 64'h30);
        step;

        // Redirect coinciding with ack while one entry is queued
        instr_ready = 1'b0;
        fetch(8'h20, 32'h1111_1111, 0, 1'b0);
        pc       = 8'h24;
        pc_valid = 1'b1;
        #1;
        check("ra_accept", 64'(pc_ready), 64'h1);
        step;
        pc_valid   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h2222_2222;
        redirect   = 1'b1;
        #1;
        check("ra_ready_low", 64'(pc_ready), 64'h0);
        step;
        imem_ack   = 1'b0;
        redirect   = 1'b0;
        imem_rdata = '0;
        #1;
        check("ra_empty", 64'(instr_valid), 64'h0);
        check("ra_req_off", 64'(imem_req), 64'h0);
        check("ra_idle", 64'(pc_ready), 64'h1);

        // Push and pop together with every slot occupied
        fetch(8'h50, 32'hAAAA_0001, 0, 1'b1);
        pc       = 8'h54;
        pc_valid = 1'b1;
        #1;
        check("fp_accept", 64'(pc_ready), 64'h1);
        step;
        pc_valid = 1'b0;
        #1;
        check("fp_full", 64'(pc_ready), 64'h0);
        check("fp_head", 64'(instr_pc), 64'h50);
        imem_ack    = 1'b1;
        imem_rdata  = 32'hBBBB_0002;
        instr_ready = 1'b1;
        sb.push_back(exp_t'{pc: 8'h54, data: 32'hBBBB_0002});
        step;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        #1;
        check("fp_valid", 64'(instr_valid), 64'h1);
        check("fp_new_head_pc", 64'(instr_pc), 64'h54);
        check("fp_new_head", 64'(instr), 64'hBBBB_0002);
        instr_ready = 1'b1;
        step;
        check("fp_count_kept", 64'(instr_valid), 64'h0);

        // Asynchronous reset in the middle of WAIT, then a stray ack
        instr_ready = 1'b0;
        fetch(8'h3C, 32'hCCCC_0003, 0, 1'b0);
        pc       = 8'h40;
        pc_valid = 1'b1;
        step;
        pc_valid = 1'b0;
        #1;
        check("ar_wait", 64'(imem_req), 64'h1);
        rst = 1'b0;
        #1;
        check("ar_req", 64'(imem_req), 64'h0);
        check("ar_valid", 64'(instr_valid), 64'h0);
        check("ar_ready", 64'(pc_ready), 64'h0);
        check("ar_addr", 64'(imem_addr), 64'h0);
        check("ar_instr", 64'(instr), 64'h0);
        check("ar_instr_pc", 64'(instr_pc), 64'h0);
        step;
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h0BAD_0BAD;
        step;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        #1;
        check("stray_valid", 64'(instr_valid), 64'h0);
        check("stray_req", 64'(imem_req), 64'h0);
        step;
        check("stray_valid2", 64'(instr_valid), 64'h0);
        instr_ready = 1'b1;

        repeat (3) step;
        check("sb_drained", 64'(sb.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
